rr_grant_arbiter: RTL
=====================

# rr_grant_arbiter

Round-robin arbiter that shares one resource among N requesters using a rotating-priority encoder search. It sits in front of any shared datapath (bus, ALU, memory port) in the Encoders/arbitration area. It registers a single one-hot grant plus its binary index and holds the grant while the owner keeps requesting. A hold limit forces rotation so no requester can starve the others.

## Interface
- N, 4: number of requesters; legal range 2..32.
- MAX_HOLD, 8: maximum consecutive grant cycles while other requests are pending; legal range ≥ 1.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit k means requester k wants the resource; level-sensitive.
- gnt  output  N  registered one-hot grant; all zero when idle.
- gnt_idx  output  $clog2(N)  binary index of the granted requester; holds the last owner when idle.
- gnt_valid  output  1  registered; high exactly when gnt is nonzero.

## Operation
- State: IDLE or GRANT. Registers: state, owner, ptr (width $clog2(N)), hold_cnt (width $clog2(MAX_HOLD+1)).
- Winner search: scan bits ptr, ptr+1, …, ptr+N-1 modulo N. The first asserted bit in the searched set wins.
- IDLE:
  - If req == 0, remain in IDLE.
  - Otherwise go to GRANT with owner = winner over req, ptr = (winner+1) mod N, hold_cnt = 0.
- GRANT, evaluated in order each cycle; others = req with the owner bit cleared:
  - Release: if req[owner] == 0 and others != 0, grant the winner over others with no idle bubble. Set ptr = winner+1 mod N and hold_cnt = 0.
  - Release: if req[owner] == 0 and others == 0, go to IDLE.
  - Preempt: if req[owner] == 1, hold_cnt == MAX_HOLD-1, and others != 0, grant the winner over others. Update ptr and clear hold_cnt.
  - Sole user: if req[owner] == 1, hold_cnt == MAX_HOLD-1, and others == 0, keep the owner and clear hold_cnt to 0.
  - Otherwise keep the owner and increment hold_cnt.
- Outputs are registered copies: gnt = (1 << owner) in GRANT, else 0. gnt_idx = owner. gnt_valid = (state == GRANT).
- Requests that appear in the same cycle resolve by the search order from ptr. After reset, ptr = 0, so the lowest index wins.
- Reset values: state IDLE, gnt = 0, gnt_idx = 0, gnt_valid = 0, ptr = 0, hold_cnt = 0.
- Reset mid-grant: all state returns to reset values on that edge. The grant is lost; the arbiter does not remember the prior owner or ptr.

## Timing
- Grant latency: 1 cycle. A req sampled at edge t produces gnt at edge t, visible in cycle t+1.
- Release latency: 1 cycle. req[owner] low at edge t moves gnt to the next owner, or to 0, at edge t.
- Handover between owners has no dead cycle. Exactly one gnt bit is set in every GRANT cycle.
- Preemption: with contention, an owner holds the grant for at most MAX_HOLD consecutive cycles.
- Fairness: under persistent all-request load, each requester is granted within (N-1)·MAX_HOLD cycles of requesting.
- gnt never asserts for a bit whose req was low at the deciding edge.

## Test plan
- Reset: assert rst for 2 cycles with req = 4'b1111. Required: gnt = 0, gnt_valid = 0, gnt_idx = 0 while rst is high. After release, the first grant is gnt = 4'b0001.
- Single requester: req = 4'b0100 from cycle 0. Required: gnt = 4'b0100 and gnt_idx = 2 from cycle 1. Drop req, then gnt = 0 and gnt_valid = 0 one cycle later.
- Rotation: req = 4'b1111, with each owner dropping its bit for 1 cycle after 2 granted cycles. Required grant order: 0, 1, 2, 3, 0, with no idle cycle between owners.
- Preemption (MAX_HOLD = 8): req[1] held high, req[3] raised 1 cycle later. Required: gnt = 4'b0010 for exactly 8 cycles, then 4'b1000.
- Sole user: req = 4'b0001 held for 20 cycles. Required: gnt = 4'b0001 continuously, with no drop when hold_cnt wraps.
- Reset mid-grant: owner = 2 and ptr = 3, assert rst for 1 cycle with req = 4'b1100. Required: gnt = 0 in the reset cycle, then gnt = 4'b0100, because ptr restarts at 0.

Source files
------------

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: rotating-priority search from ptr, registered one-hot grant held while requested.
// Grant/release take effect on the deciding edge (1-cycle latency); a hold limit forces rotation under contention.
module rr_grant_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [N-1:0]    gnt_q, gnt_d;

    logic [N-1:0]    others;
    logic [IW-1:0]   win_req;
    logic [IW-1:0]   win_oth;

    // First set bit scanning start, start+1, ... modulo N.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] vec, input logic [IW-1:0] start);
        logic [IW-1:0] win;
        logic          found;
        int            idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(start) + i) % N;
            if (!found && vec[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
        return win;
    endfunction

    function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] w);
        logic [IW-1:0] nxt;
        if (w == IW'(N - 1)) nxt = '0;
        else                 nxt = w + 1'b1;
        return nxt;
    endfunction

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        others     = req & ~(N'(1) << owner_q);
        win_req    = rr_pick(req, ptr_q);
        win_oth    = rr_pick(others, ptr_q);

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = GRANT;
                    owner_d    = win_req;
                    ptr_d      = ptr_after(win_req);
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!req[owner_q]) begin
                    if (|others) begin
                        owner_d    = win_oth;
                        ptr_d      = ptr_after(win_oth);
                        hold_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (hold_cnt_q == HOLD_LAST) begin
                    // Limit reached: rotate if anyone else waits, otherwise just restart the count.
                    hold_cnt_d = '0;
                    if (|others) begin
                        owner_d = win_oth;
                        ptr_d   = ptr_after(win_oth);
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        gnt_d = (state_d == GRANT) ? (N'(1) << owner_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = owner_q;
    assign gnt_valid = (state_q == GRANT);

endmodule
